// File: rtl/axistream_downsizer_pkg.sv
// axistream_downsizer_pkg: shared widths and buffer entry type for the 64->32 AXI Stream downsizer
package axistream_downsizer_pkg;
  localparam int IN_W  = 64;
  localparam int OUT_W = 32;
  localparam int DEPTH = 2;
  typedef struct packed {
    logic [IN_W-1:0] data;
    logic            last;
  } entry_t;
endpackage

// File: rtl/axistream_downsizer_fifo.sv
// axis_skid_fifo2: two-entry circular queue with registered ready, outputs straight from storage
module axis_skid_fifo2
  import axistream_downsizer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_valid,
  input  logic [IN_W-1:0] push_data,
  input  logic            push_last,
  output logic            push_ready,
  input  logic            pop,
  output logic            head_valid,
  output logic [IN_W-1:0] head_data,
  output logic            head_last
);
  entry_t     mem_q [DEPTH];
  entry_t     mem_d [DEPTH];
  logic       head_q, head_d;
  logic [1:0] occ_q, occ_d;
  logic       ready_q, ready_d;
  logic       push, pop_ok, wr_idx;
  // next-state: write lands at (head+occupancy) mod 2, so a same-cycle pop/push stays in order
  always_comb begin
    push    = push_valid && ready_q;
    pop_ok  = pop && (occ_q != 2'd0);
    wr_idx  = head_q ^ occ_q[0];
    head_d  = head_q ^ pop_ok;
    occ_d   = occ_q + 2'(push) - 2'(pop_ok);
    ready_d = occ_d < 2'(DEPTH);
    mem_d   = mem_q;
    if (push) mem_d[wr_idx] = '{data: push_data, last: push_last};
  end
  // control state clears asynchronously; ready comes up on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= 1'b0;
      occ_q   <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      occ_q   <= occ_d;
      ready_q <= ready_d;
    end
  end
  // payload storage needs no reset, occupancy gates its visibility
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
  assign push_ready = ready_q;
  assign head_valid = occ_q != 2'd0;
  assign head_data  = mem_q[head_q].data;
  assign head_last  = mem_q[head_q].last;
endmodule

// File: rtl/axistream_downsizer.sv
// axistream_downsizer: splits 64-bit AXI Stream flits into two 32-bit words and counts emitted packets
module axistream_downsizer
  import axistream_downsizer_pkg::*;
#(
  parameter bit HI_FIRST  = 1'b1,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_W-1:0]      S_TDATA,
  input  logic                 S_TVALID,
  input  logic                 S_TLAST,
  output logic                 S_TREADY,
  output logic [OUT_W-1:0]     M_TDATA,
  output logic                 M_TVALID,
  output logic                 M_TLAST,
  input  logic                 M_TREADY,
  output logic [CNT_WIDTH-1:0] packet_count
);
  logic                 head_valid, head_last;
  logic [IN_W-1:0]      head_data;
  logic                 half_q, half_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 beat;
  axis_skid_fifo2 u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (S_TVALID),
    .push_data  (S_TDATA),
    .push_last  (S_TLAST),
    .push_ready (S_TREADY),
    .pop        (beat && half_q),
    .head_valid (head_valid),
    .head_data  (head_data),
    .head_last  (head_last)
  );
  // each beat toggles the half; the second half's beat pops the entry and may close a packet
  always_comb begin
    beat   = head_valid && M_TREADY;
    half_d = half_q ^ beat;
    cnt_d  = cnt_q + CNT_WIDTH'(beat && M_TLAST);
  end
  // half-select and packet counter, cleared asynchronously with the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      half_q <= half_d;
      cnt_q  <= cnt_d;
    end
  end
  assign M_TVALID     = head_valid;
  assign M_TLAST      = head_last && half_q;
  assign M_TDATA      = (half_q ^ HI_FIRST) ? head_data[IN_W-1:OUT_W] : head_data[OUT_W-1:0];
  assign packet_count = cnt_q;
endmodule

// File: doc/axistream_downsizer.md
Name: axistream_downsizer

Overview:
- Downstream neighbour of the AXI Stream packet forwarder. Consumes its 64-bit flit stream and emits a 32-bit AXI Stream for narrower egress logic, such as 32-bit MAC shims or debug FIFOs.
- A 2-entry registered buffer decouples both sides, so S_TREADY never combinationally depends on M_TREADY.
- Counts emitted packets for status readback.

Parameters:
- HI_FIRST, 1, 1: emit S_TDATA[63:32] before [31:0]; 0: low word first.
- CNT_WIDTH, 32, width of the packet_count output.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- S_TDATA  in  64  input flit
- S_TVALID  in  1  input flit valid
- S_TLAST  in  1  input flit is last of packet
- S_TREADY  out  1  registered; buffer can accept a flit this cycle
- M_TDATA  out  32  output word
- M_TVALID  out  1  output word valid
- M_TLAST  out  1  output word is last of packet
- M_TREADY  in  1  downstream accepts the word
- packet_count  out  CNT_WIDTH  number of packets fully emitted, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (rst_n low, async):
  - occupancy=0, half=0, head=0.
  - S_TREADY=0, M_TVALID=0, packet_count=0.
  - Buffer contents are don't-care.
  - First rising edge after release sets S_TREADY=1.
  - Reset mid-packet discards all buffered data and emits no partial packet.
- Storage:
  - Two entries {data[63:0], last}, forming a circular queue with a head pointer and occupancy 0..2.
  - half selects which 32-bit half of the head entry is presented.
- Push: when S_TVALID && S_TREADY, write the flit at (head+occupancy) mod 2.
- Output:
  - M_TVALID = (occupancy != 0).
  - M_TDATA: if HI_FIRST, half==0 presents data[63:32] and half==1 presents data[31:0]; if HI_FIRST=0, the mapping is reversed.
  - M_TLAST = head.last && half==1.
- Beat (M_TVALID && M_TREADY):
  - half==0: set half to 1.
  - half==1: set half to 0, pop (head flips, occupancy decrements).
- Simultaneous push and pop in one cycle leaves occupancy unchanged. The new flit lands in the freed slot order-correctly.
- S_TREADY is registered: S_TREADY <= (occupancy_next < 2).
  - It never deasserts while a flit is held off, except via the full condition.
  - A push into a full buffer cannot occur.
- M_TDATA, M_TVALID and M_TLAST stay stable while M_TVALID && !M_TREADY (AXI rule). The outputs are driven directly from storage registers and half.
- Latency: a flit accepted on edge N is presented on M starting the cycle after edge N.
- Throughput:
  - One output word per cycle sustained.
  - The input sustains one flit per 2 cycles once the buffer fills; no bubbles are inserted on M while occupancy>0.
- packet_count increments by 1 on each beat with M_TLAST=1. It wraps from all-ones to 0.
- A single-flit packet (S_TLAST on its first flit) emits 2 words, with M_TLAST on the second.
- No packet-length checking: every flit always yields exactly 2 words.

Decomposition:
- A shared package holds:
  - the entry struct {data, last};
  - localparams IN_W=64, OUT_W=32, DEPTH=2.
- Natural sub-module: axis_skid_fifo2. It is the 2-entry registered queue with push/pop, occupancy and registered ready. The downsizer adds only the half-select, data mux, TLAST gating and counter.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release. Required: M_TVALID=0 and packet_count=0 throughout; S_TREADY=0 during reset, 1 one cycle after release.
- Basic order: HI_FIRST=1, flits 0x11112222_33334444 then 0x55556666_77778888 with TLAST, M_TREADY=1. Required words in order: 0x11112222, 0x33334444, 0x55556666, 0x77778888 (TLAST only on last); packet_count=1.
- Backpressure: hold M_TREADY=0 for 10 cycles with S_TVALID=1. Required: exactly 2 flits accepted, then S_TREADY=0; M_TDATA stable. On release, all 4 words arrive in order with no loss.
- Single-flit packets back-to-back: 3 flits, each with TLAST, M_TREADY=1. Required: 6 words with TLAST on words 2, 4 and 6; packet_count=3; no idle cycles on M.
- HI_FIRST=0 with flit 0xAAAAAAAA_BBBBBBBB. Required: 0xBBBBBBBB first, then 0xAAAAAAAA with TLAST.
- Reset mid-packet: assert rst_n=0 while occupancy=2 and half=1. Required: M_TVALID drops immediately (async); no stale words after release; the next packet is emitted intact. Counter wrap: with CNT_WIDTH=2, 5 packets give packet_count=1.
